// File: rtl/jk_ff_bank.sv
// Bank of N JK flip-flops with whole-bank counter, shift and hold modes; per-channel sync preset/clear.
// Q/QN update one Clk edge after inputs are sampled, TC is combinational; no backpressure, every edge is accepted.
module jk_ff_bank #(
  parameter int N = 2
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         CE,
  input  logic [1:0]   Mode,
  input  logic         Up,
  input  logic         SerIn,
  input  logic [1:N]   J,
  input  logic [1:N]   K,
  input  logic [1:N]   SD,
  input  logic [1:N]   RD,
  output logic [1:N]   Q,
  output logic [1:N]   QN,
  output logic         SerOut,
  output logic         TC
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_CNT   = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic [1:N]   q_r;
  logic [1:N]   qn_r;
  logic [1:N]   mode_q;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_nxt;
  logic         cnt_all_ones;
  logic         cnt_all_zeros;

  // Channel 1 is the counter LSB, so the [1:N] bank is bit-reversed into a plain binary word.
  always_comb begin
    cnt = '0;
    for (int i = 1; i <= N; i++) begin
      cnt[i-1] = q_r[i];
    end
    cnt_nxt       = Up ? (cnt + CNT_ONE) : (cnt - CNT_ONE);
    cnt_all_ones  = &cnt;
    cnt_all_zeros = ~|cnt;
  end

  always_comb begin
    mode_q = q_r;
    case (Mode)
      MODE_JK: begin
        for (int i = 1; i <= N; i++) begin
          case ({J[i], K[i]})
            2'b01:   mode_q[i] = 1'b0;
            2'b10:   mode_q[i] = 1'b1;
            2'b11:   mode_q[i] = ~q_r[i];
            default: mode_q[i] = q_r[i];
          endcase
        end
      end
      MODE_CNT: begin
        for (int i = 1; i <= N; i++) begin
          mode_q[i] = cnt_nxt[i-1];
        end
      end
      MODE_SHIFT: begin
        mode_q[1] = SerIn;
        for (int i = 2; i <= N; i++) begin
          mode_q[i] = q_r[i-1];
        end
      end
      MODE_HOLD: mode_q = q_r;
      default:   mode_q = q_r;
    endcase
  end

  // QN is its own flop so SD=RD=0 can drive both outputs high; otherwise it tracks ~Q.
  always_ff @(posedge Clk) begin
    for (int i = 1; i <= N; i++) begin
      if (Rst) begin
        q_r[i]  <= 1'b0;
        qn_r[i] <= 1'b1;
      end else if (!SD[i] || !RD[i]) begin
        q_r[i]  <= ~SD[i];
        qn_r[i] <= ~RD[i];
      end else if (!CE) begin
        qn_r[i] <= ~q_r[i];
      end else begin
        q_r[i]  <= mode_q[i];
        qn_r[i] <= ~mode_q[i];
      end
    end
  end

  assign Q      = q_r;
  assign QN     = qn_r;
  assign SerOut = q_r[N];
  assign TC     = (Mode == MODE_CNT) && CE && !Rst && (Up ? cnt_all_ones : cnt_all_zeros);

endmodule

// File: tb/tb_jk_ff_bank.sv
// Randomized and directed bench for jk_ff_bank (N=4) against a count/array level reference model.
module tb_jk_ff_bank;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [1:0] mode;
  logic       up;
  logic       ser_in;
  logic [1:4] j;
  logic [1:4] k;
  logic [1:4] sd;
  logic [1:4] rd;
  logic [1:4] q;
  logic [1:4] qn;
  logic       ser_out;
  logic       tc;

  jk_ff_bank #(.N(4)) dut (
    .Clk(clk), .Rst(rst), .CE(ce), .Mode(mode), .Up(up), .SerIn(ser_in),
    .J(j), .K(k), .SD(sd), .RD(rd),
    .Q(q), .QN(qn), .SerOut(ser_out), .TC(tc)
  );

  typedef struct {
    logic [1:4] q;
    logic [1:4] qn;
    logic       so;
  } st_t;

  logic [1:4] m_q;
  logic [1:4] m_qn;
  logic       tc_q[$];
  st_t        st_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int cval(input logic [1:4] v);
    int c = 0;
    for (int i = 1; i <= 4; i++) if (v[i]) c += (1 << (i - 1));
    return c;
  endfunction

  function automatic logic [1:4] from_c(input int c);
    logic [1:4] v;
    for (int i = 1; i <= 4; i++) v[i] = ((c >> (i - 1)) & 1) != 0;
    return v;
  endfunction

  function automatic logic model_tc();
    int c = cval(m_q);
    return (mode == 2'b01) && ce && !rst && (up ? (c == 15) : (c == 0));
  endfunction

  function automatic void model_update();
    logic [1:4] nm;
    int c;
    nm = m_q;
    if (rst) begin
      m_q  = 4'b0000;
      m_qn = 4'b1111;
      return;
    end
    case (mode)
      2'b00: for (int i = 1; i <= 4; i++) begin
        if (j[i] && k[i])  nm[i] = !m_q[i];
        else if (j[i])     nm[i] = 1'b1;
        else if (k[i])     nm[i] = 1'b0;
      end
      2'b01: begin
        c  = up ? (cval(m_q) + 1) % 16 : (cval(m_q) + 15) % 16;
        nm = from_c(c);
      end
      2'b10: nm = {ser_in, m_q[1:3]};
      default: nm = m_q;
    endcase
    for (int i = 1; i <= 4; i++) begin
      if (!sd[i] && !rd[i])      begin m_q[i] = 1'b1; m_qn[i] = 1'b1; end
      else if (!sd[i])           begin m_q[i] = 1'b1; m_qn[i] = 1'b0; end
      else if (!rd[i])           begin m_q[i] = 1'b0; m_qn[i] = 1'b1; end
      else if (!ce)              m_qn[i] = !m_q[i];
      else                       begin m_q[i] = nm[i]; m_qn[i] = !nm[i]; end
    end
  endfunction

  // Called at posedge+1: drive, record TC for this cycle, cross one edge, record resulting state.
  task automatic step(input logic r, input logic c, input logic [1:0] m, input logic u, input logic s,
                      input logic [1:4] jj, input logic [1:4] kk, input logic [1:4] sdd, input logic [1:4] rdd);
    st_t e;
    rst = r; ce = c; mode = m; up = u; ser_in = s; j = jj; k = kk; sd = sdd; rd = rdd;
    tc_q.push_back(model_tc());
    @(posedge clk);
    #1;
    model_update();
    e.q = m_q; e.qn = m_qn; e.so = m_q[4];
    st_q.push_back(e);
  endtask

  initial begin
    logic e_tc;
    st_t  e;
    forever begin
      @(negedge clk);
      if (tc_q.size() > 0) begin
        e_tc = tc_q.pop_front();
        chk("sb_tc", {3'b000, tc}, {3'b000, e_tc});
      end
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("sb_q", q, e.q);
        chk("sb_qn", qn, e.qn);
        chk("sb_serout", {3'b000, ser_out}, {3'b000, e.so});
      end
    end
  end

  localparam logic [1:4] Z = 4'b0000;
  localparam logic [1:4] F = 4'b1111;

  initial begin
    logic [1:4] hold_q;
    logic       so_seq[4];
    logic       sin_seq[4];
    m_q = 4'bxxxx; m_qn = 4'bxxxx;
    rst = 1'b1; ce = 1'b1; mode = 2'b00; up = 1'b1; ser_in = 1'b0; j = F; k = F; sd = F; rd = F;
    @(posedge clk);
    #1;

    // Reset with J=K=1 in JK mode, then release toggles every channel.
    step(1, 1, 2'b00, 0, 0, F, F, F, F);
    step(1, 1, 2'b00, 0, 0, F, F, F, F);
    chk("rst_q", q, Z);
    chk("rst_qn", qn, F);
    chk("rst_tc", {3'b000, tc}, 4'b0000);
    step(0, 1, 2'b00, 0, 0, F, F, F, F);
    chk("rst_release_q", q, F);
    chk("rst_release_qn", qn, Z);

    // JK truth table from zero.
    step(1, 1, 2'b00, 0, 0, Z, Z, F, F);
    step(0, 1, 2'b00, 0, 0, Z, Z, F, F);
    chk("jk_hold", q, Z);
    step(0, 1, 2'b00, 0, 0, Z, F, F, F);
    chk("jk_reset", q, Z);
    step(0, 1, 2'b00, 0, 0, F, Z, F, F);
    chk("jk_set", q, F);
    step(0, 1, 2'b00, 0, 0, F, F, F, F);
    chk("jk_toggle", q, Z);
    step(0, 1, 2'b00, 0, 0, 4'b1100, 4'b0011, F, F);
    chk("jk_mixed_q", q, 4'b1100);
    chk("jk_mixed_qn", qn, 4'b0011);

    // Preset/clear, both-low, release.
    step(0, 1, 2'b00, 0, 0, Z, Z, 4'b1010, 4'b0101);
    chk("pc_q", q, 4'b0101);
    step(0, 1, 2'b00, 0, 0, Z, Z, Z, Z);
    chk("pc_both_q", q, F);
    chk("pc_both_qn", qn, F);
    step(0, 1, 2'b00, 0, 0, Z, Z, F, F);
    chk("pc_release_q", q, F);
    chk("pc_release_qn", qn, Z);

    // Counter up through wrap, down from zero, reset mid-count.
    step(1, 1, 2'b01, 1, 0, Z, Z, F, F);
    for (int i = 0; i < 15; i++) step(0, 1, 2'b01, 1, 0, F, F, F, F);
    chk("cnt_15", 4'(cval(q)), 4'd15);
    chk("cnt_tc_15", {3'b000, tc}, 4'b0001);
    step(0, 1, 2'b01, 1, 0, Z, Z, F, F);
    chk("cnt_wrap", 4'(cval(q)), 4'd0);
    chk("cnt_tc_wrap", {3'b000, tc}, 4'b0000);
    step(0, 1, 2'b01, 0, 0, Z, Z, F, F);
    chk("cnt_down_wrap", 4'(cval(q)), 4'd15);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b01, 1, 0, Z, Z, F, F);
    chk("cnt_7", 4'(cval(q)), 4'd7);
    step(1, 1, 2'b01, 1, 0, Z, Z, F, F);
    chk("cnt_rst", 4'(cval(q)), 4'd0);

    // Shift in 1,0,1,1.
    sin_seq = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'b10, 0, sin_seq[i], Z, Z, F, F);
      so_seq[i] = ser_out;
    end
    chk("shift_q", q, 4'b1101);
    chk("shift_so", {so_seq[0], so_seq[1], so_seq[2], so_seq[3]}, 4'b0001);

    // CE=0 holds in every mode.
    hold_q = q;
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 3; i++) step(0, 0, 2'(m), 1, 1, F, F, F, F);
    chk("ce_hold", q, hold_q);
    step(0, 0, 2'b00, 0, 0, F, F, F, 4'b0111);
    chk("ce_clear", q, 4'b0101);
    step(0, 1, 2'b11, 0, 1, F, F, F, F);
    chk("mode_hold", q, 4'b0101);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom),
           4'($urandom | $urandom | $urandom), 4'($urandom | $urandom | $urandom));
    end

    @(negedge clk);
    @(negedge clk);
    chk("queues_drained", 4'(tc_q.size() + st_q.size()), 4'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
